mult_div_unit: RTL

Multicycle integer multiply/divide unit for the datapath. It consumes the two register-file read values (Data1, Data2) on a start request and computes a 64-bit product or a 32-bit quotient/remainder pair with a radix-2 shift-add/shift-subtract engine. It holds the result in HI/LO output registers until the next operation completes, and signals completion to the control unit with a one-cycle `done` pulse.

---
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Radix-2 multicycle multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, HI/LO result registers.
// Optional macro MDU_ZERO_SKIP_EN: multiplies with a zero operand finish one cycle after accept.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               skip;
    logic               skip_dz;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    // Accept-cycle decode
    logic             sgn, a_neg, b_neg, dz_hit, zero_hit, calc_last;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sgn    = ~op[0];
    assign a_neg  = sgn & a[WIDTH-1];
    assign b_neg  = sgn & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign dz_hit = op[1] & (b == '0);
`ifdef MDU_ZERO_SKIP_EN
    assign zero_hit = ~op[1] & ((a == '0) | (b == '0));
`else
    assign zero_hit = 1'b0;
`endif
    assign calc_last = (cnt == CNT_W'(WIDTH - 1));

    // One radix-2 step: acc = {upper, lower}; upper is partial product / remainder.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_nxt;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign fix-up applied in SIGN
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    assign prod_fix = neg_lo ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (skip) begin
            res_hi = acc[2*WIDTH-1:WIDTH];
            res_lo = acc[WIDTH-1:0];
        end else if (is_div) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Shortcut ops spend their single busy cycle in SIGN so results land one edge after accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (dz_hit | zero_hit) ? SIGN : CALC;
            CALC: if (calc_last) state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            skip        <= 1'b0;
            skip_dz     <= 1'b0;
            opnd        <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt     <= '0;
                    is_div  <= op[1];
                    neg_lo  <= a_neg ^ b_neg;
                    neg_hi  <= a_neg;
                    skip    <= dz_hit | zero_hit;
                    skip_dz <= dz_hit;
                    opnd    <= op[1] ? b_mag : a_mag;
                    // Shortcut results are preloaded into acc and passed through unchanged.
                    if (dz_hit)        acc <= {a, {WIDTH{1'b1}}};
                    else if (zero_hit) acc <= '0;
                    else if (op[1])    acc <= {{WIDTH{1'b0}}, a_mag};
                    else               acc <= {{WIDTH{1'b0}}, b_mag};
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_nxt : mul_nxt;
                end
                SIGN: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= skip & skip_dz;
                end
                default: ;
            endcase
        end
    end

endmodule
